// File: rtl/ibex_pmc_unit_if.sv
// Request handshake and PMC register-file write port of the performance-monitor
// counter unit. The master side is ID/EX plus the RF arbitration inputs; the
// slave side is the counter unit.
interface ibex_pmc_unit_if #(
  parameter int unsigned NumCounters = 8
);
  localparam int unsigned IdxW = (NumCounters > 1) ? $clog2(NumCounters) : 1;

  // Request channel from ID/EX
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      req_op_i;
  logic [IdxW-1:0] req_idx_i;
  logic            req_hi_i;
  logic [31:0]     req_wdata_i;
  logic [4:0]      req_waddr_i;

  // Higher-priority RF writers
  logic            rf_we_id_i;
  logic            rf_we_lsu_i;

  // PMC RF write port
  logic            rf_we_pmc_o;
  logic [4:0]      rf_waddr_pmc_o;
  logic [31:0]     rf_wdata_pmc_o;

  modport master (
    output req_valid_i, req_op_i, req_idx_i, req_hi_i, req_wdata_i, req_waddr_i,
    output rf_we_id_i, rf_we_lsu_i,
    input  req_ready_o, rf_we_pmc_o, rf_waddr_pmc_o, rf_wdata_pmc_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_idx_i, req_hi_i, req_wdata_i, req_waddr_i,
    input  rf_we_id_i, rf_we_lsu_i,
    output req_ready_o, rf_we_pmc_o, rf_waddr_pmc_o, rf_wdata_pmc_o
  );
endinterface

// File: rtl/ibex_pmc_unit.sv
// Performance-monitor counter unit: NumCounters event counters with sticky
// wrap flags, serviced by read/write/clear requests. Read results go back to
// the register file through a PMC write port that yields to ID and LSU writes.
module ibex_pmc_unit #(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCounters-1:0] event_i,
  input  logic                   freeze_i,
  ibex_pmc_unit_if.slave         bus,
  output logic [NumCounters-1:0] overflow_o,
  output logic                   busy_o
);

  localparam int unsigned IdxW = (NumCounters > 1) ? $clog2(NumCounters) : 1;
  localparam int unsigned HiW  = CounterWidth - 32;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e                  state_q, state_d;
  logic [CounterWidth-1:0] cnt_q [NumCounters];
  logic [CounterWidth-1:0] cnt_d [NumCounters];
  logic [NumCounters-1:0]  ovf_q, ovf_d;
  logic [4:0]              res_addr_q, res_addr_d;
  logic [31:0]             res_data_q, res_data_d;

  logic        accept;
  logic        is_read, is_write, is_clear;
  logic        rf_we;
  logic [31:0] rd_val;

  assign accept   = bus.req_valid_i & (state_q == StIdle);
  assign is_read  = accept & (bus.req_op_i == OpRead);
  assign is_write = accept & (bus.req_op_i == OpWrite);
  assign is_clear = accept & (bus.req_op_i == OpClear);

  // PMC write only when neither ID nor LSU claims the RF port this cycle.
  assign rf_we = (state_q == StResp) & ~bus.rf_we_id_i & ~bus.rf_we_lsu_i;

  assign bus.req_ready_o    = (state_q == StIdle);
  assign bus.rf_we_pmc_o    = rf_we;
  assign bus.rf_waddr_pmc_o = res_addr_q;
  assign bus.rf_wdata_pmc_o = res_data_q;
  assign overflow_o         = ovf_q;
  assign busy_o             = (state_q == StResp);

  // Select the requested half of the pre-increment counter value
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (bus.req_idx_i == IdxW'(i)) begin
        if (bus.req_hi_i) begin
          rd_val = 32'(cnt_q[i][CounterWidth-1:32]);
        end else begin
          rd_val = cnt_q[i][31:0];
        end
      end
    end
  end

  // Counter and overflow next state; an accepted write/clear beats the event
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NumCounters; i++) begin
      if ((is_write || is_clear) && (bus.req_idx_i == IdxW'(i))) begin
        if (is_clear) begin
          cnt_d[i] = '0;
          ovf_d[i] = 1'b0;
        end else if (bus.req_hi_i) begin
          cnt_d[i][CounterWidth-1:32] = bus.req_wdata_i[HiW-1:0];
        end else begin
          cnt_d[i][31:0] = bus.req_wdata_i;
        end
      end else if (event_i[i] && !freeze_i) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Response FSM and result capture
  always_comb begin
    state_d    = state_q;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    unique case (state_q)
      StIdle: begin
        // A read to x0 is accepted and silently retired in IDLE.
        if (is_read && (bus.req_waddr_i != 5'd0)) begin
          state_d    = StResp;
          res_addr_d = bus.req_waddr_i;
          res_data_d = rd_val;
        end
      end
      StResp: begin
        if (rf_we) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any pending read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ovf_q      <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
